// File: rtl/countdown_timer_pkg.sv
// rtl/countdown_timer_pkg.sv - shared state encoding and derived-constant helpers for countdown_timer
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  // Prescaler compare value: last count before a tick is issued.
  function automatic int prescale_max(input int clock_freq, input int tick_div);
    return (clock_freq / tick_div) - 1;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - control/status bundle between the button pulses and countdown_timer
interface countdown_timer_if #(
  parameter int BIT_DEPTH          = 16,
  parameter int MEM_ADDR_BIT_DEPTH = 2
);

  logic                          start_stop;
  logic                          load;
  logic                          store;
  logic [MEM_ADDR_BIT_DEPTH-1:0] select;
  logic [BIT_DEPTH-1:0]          preset_in;
  logic [BIT_DEPTH-1:0]          remaining;
  logic                          running;
  logic                          alarm;
  logic                          done;

  modport master (
    output start_stop, load, store, select, preset_in,
    input  remaining, running, alarm, done
  );

  modport slave (
    input  start_stop, load, store, select, preset_in,
    output remaining, running, alarm, done
  );

endinterface

// File: rtl/countdown_timer_tick.sv
// rtl/countdown_timer_tick.sv - enable-gated prescaler issuing one tick every MAX_COUNT+1 enabled cycles
module countdown_timer_tick
  import countdown_timer_pkg::*;
#(
  parameter int MAX_COUNT = 9
) (
  input  logic clk,
  input  logic reset_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int W = cnt_width(MAX_COUNT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Wrap to zero is done by the parent folding tick_o back into reset_i.
  assign tick_o = enable_i && (cnt_q == W'(MAX_COUNT));

  always_comb begin
    cnt_d = cnt_q;
    if (enable_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - preset countdown with slot memory and sticky alarm; COUNTDOWN_TIMER_AUTO_RELOAD_EN enables auto reload
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int BIT_DEPTH          = 16,
  parameter int MEM_SIZE           = 4,
  parameter int MEM_ADDR_BIT_DEPTH = 2,
  parameter int CLOCK_FREQ         = 50000000,
  parameter int TICK_DIV           = 10
) (
  input  logic             clk,
  input  logic             reset,
  countdown_timer_if.slave bus
);

  localparam int PRESCALE_MAX = prescale_max(CLOCK_FREQ, TICK_DIV);

  state_e               state_q;
  state_e               state_d;
  logic [BIT_DEPTH-1:0] remaining_q;
  logic [BIT_DEPTH-1:0] remaining_d;
  logic                 done_q;
  logic                 done_d;
  logic [BIT_DEPTH-1:0] slot_q [MEM_SIZE];

  logic [BIT_DEPTH-1:0] slot_rd;
  logic                 sel_hit;
  logic                 tick;
  logic                 start_from_idle;
  logic                 load_take;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [BIT_DEPTH-1:0] reload_q;
  logic [BIT_DEPTH-1:0] reload_d;
`endif

  // Out-of-range selects simply never match, so they read and write nothing.
  always_comb begin
    slot_rd = '0;
    sel_hit = 1'b0;
    for (int i = 0; i < MEM_SIZE; i++) begin
      if (bus.select == MEM_ADDR_BIT_DEPTH'(i)) begin
        slot_rd = slot_q[i];
        sel_hit = 1'b1;
      end
    end
  end

  countdown_timer_tick #(
    .MAX_COUNT (PRESCALE_MAX)
  ) u_tick (
    .clk      (clk),
    .reset_i  (reset || load_take || start_from_idle || tick),
    .enable_i (state_q == ST_RUN),
    .tick_o   (tick)
  );

  always_comb begin
    state_d         = state_q;
    remaining_d     = remaining_q;
    done_d          = 1'b0;
    start_from_idle = 1'b0;
    load_take       = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    reload_d        = reload_q;
`endif

    if (state_q == ST_RUN) begin
      if (tick) begin
        remaining_d = remaining_q - BIT_DEPTH'(1);
        if (remaining_q == BIT_DEPTH'(1)) begin
          done_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
          if (reload_q != '0) begin
            remaining_d = reload_q;
            if (bus.start_stop) begin
              state_d = ST_PAUSE;
            end
          end else begin
            state_d = ST_ALARM;
          end
`else
          state_d = ST_ALARM;
`endif
        end else if (bus.start_stop) begin
          state_d = ST_PAUSE;
        end
      end else if (bus.start_stop) begin
        state_d = ST_PAUSE;
      end
    end else if (bus.start_stop) begin
      unique case (state_q)
        ST_IDLE: begin
          if (remaining_q != '0) begin
            state_d         = ST_RUN;
            start_from_idle = 1'b1;
          end
        end
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end else if (bus.load && sel_hit) begin
      load_take   = 1'b1;
      remaining_d = slot_rd;
      state_d     = ST_IDLE;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_d    = slot_rd;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      done_q      <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_q    <= reload_d;
`endif
    end
  end

  // Store reads no state, so it lands alongside whatever else happens this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        slot_q[i] <= '0;
      end
    end else if (bus.store) begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        if (bus.select == MEM_ADDR_BIT_DEPTH'(i)) begin
          slot_q[i] <= bus.preset_in;
        end
      end
    end
  end

  assign bus.remaining = remaining_q;
  assign bus.running   = (state_q == ST_RUN);
  assign bus.alarm     = (state_q == ST_ALARM);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - vector table, corner sequences and random run against a reference model
module tb_countdown_timer;

  localparam int BD  = 16;
  localparam int MS  = 3;
  localparam int AW  = 2;
  localparam int CF  = 100;
  localparam int TD  = 10;
  localparam int DIV = CF / TD;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  countdown_timer_if #(.BIT_DEPTH(BD), .MEM_ADDR_BIT_DEPTH(AW)) bus ();

  countdown_timer #(
    .BIT_DEPTH          (BD),
    .MEM_SIZE           (MS),
    .MEM_ADDR_BIT_DEPTH (AW),
    .CLOCK_FREQ         (CF),
    .TICK_DIV           (TD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_ALARM} mstate_t;
  mstate_t m_st = M_IDLE;
  int      m_rem = 0;
  int      m_reload = 0;
  int      m_slot [MS];
  int      m_since_tick = 0;
  bit      m_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behaviour rules: run time accumulates only while running; every DIV run cycles one unit elapses.
  task automatic model_step(input bit rst, input bit ss, input bit ld, input bit st,
                            input int sel, input int pin);
    bit ok;
    int rd;
    ok = (sel < MS);
    rd = ok ? m_slot[sel] : 0;
    m_done = 1'b0;
    if (rst) begin
      m_st = M_IDLE; m_rem = 0; m_reload = 0; m_since_tick = 0;
      foreach (m_slot[i]) m_slot[i] = 0;
      return;
    end
    if (st && ok) m_slot[sel] = pin % (1 << BD);
    if (m_st == M_RUN) begin
      m_since_tick++;
      if (m_since_tick == DIV) begin
        m_since_tick = 0;
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_done = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
          if (m_reload != 0) m_rem = m_reload;
          else m_st = M_ALARM;
`else
          m_st = M_ALARM;
`endif
        end
      end
      if (ss && m_st == M_RUN) m_st = M_PAUSE;
    end else if (ss) begin
      if (m_st == M_IDLE && m_rem != 0) begin m_st = M_RUN; m_since_tick = 0; end
      else if (m_st == M_PAUSE) m_st = M_RUN;
      else if (m_st == M_ALARM) m_st = M_IDLE;
    end else if (ld && ok) begin
      m_rem = rd; m_reload = rd; m_st = M_IDLE; m_since_tick = 0;
    end
  endtask

  task automatic cycle(input bit rst, input bit ss, input bit ld, input bit st,
                       input int sel, input int pin);
    reset          = rst;
    bus.start_stop = ss;
    bus.load       = ld;
    bus.store      = st;
    bus.select     = AW'(sel);
    bus.preset_in  = BD'(pin);
    model_step(rst, ss, ld, st, sel, pin);
    @(posedge clk);
    #1;
    chk("model_remaining", 32'(bus.remaining), 32'(m_rem));
    chk("model_running", 32'(bus.running), 32'(m_st == M_RUN));
    chk("model_alarm", 32'(bus.alarm), 32'(m_st == M_ALARM));
    chk("model_done", 32'(bus.done), 32'(m_done));
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  typedef struct {
    bit rst; bit ss; bit ld; bit st; int sel; int pin;
    int e_rem; bit e_run; bit e_alarm; bit e_done;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int first_done;
    int done_cnt;
    int alarm_seen;

    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 1, 2, 5, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 1, 0, 2, 0, 5, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 1, 3, 9, 5, 0, 0, 0};
    vecs[4]  = '{0, 0, 1, 0, 3, 0, 5, 0, 0, 0};
    vecs[5]  = '{0, 0, 0, 1, 1, 7, 5, 0, 0, 0};
    vecs[6]  = '{0, 0, 1, 0, 1, 0, 7, 0, 0, 0};
    vecs[7]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{0, 0, 1, 0, 2, 0, 5, 0, 0, 0};
    vecs[10] = '{0, 1, 0, 0, 0, 0, 5, 1, 0, 0};
    vecs[11] = '{0, 0, 1, 0, 1, 0, 5, 1, 0, 0};
    vecs[12] = '{0, 1, 0, 0, 0, 0, 5, 0, 0, 0};
    vecs[13] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[14] = '{0, 0, 1, 0, 2, 0, 0, 0, 0, 0};

    foreach (m_slot[i]) m_slot[i] = 0;

    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].rst, vecs[i].ss, vecs[i].ld, vecs[i].st, vecs[i].sel, vecs[i].pin);
      chk($sformatf("vec%0d_remaining", i), 32'(bus.remaining), 32'(vecs[i].e_rem));
      chk($sformatf("vec%0d_running", i), 32'(bus.running), 32'(vecs[i].e_run));
      chk($sformatf("vec%0d_alarm", i), 32'(bus.alarm), 32'(vecs[i].e_alarm));
      chk($sformatf("vec%0d_done", i), 32'(bus.done), 32'(vecs[i].e_done));
    end

`ifndef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    // Full countdown from 5: done exactly once at clk 50, then acknowledge.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 2, 5);
    cycle(0, 0, 1, 0, 2, 0);
    cycle(0, 1, 0, 0, 0, 0);
    first_done = -1;
    done_cnt = 0;
    for (int n = 1; n <= 60; n++) begin
      idle();
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = n;
      end
    end
    chk("t2_done_clk", 32'(first_done), 32'd50);
    chk("t2_done_width", 32'(done_cnt), 32'd1);
    chk("t2_alarm", 32'(bus.alarm), 32'd1);
    chk("t2_running", 32'(bus.running), 32'd0);
    chk("t2_remaining", 32'(bus.remaining), 32'd0);
    cycle(0, 1, 0, 0, 0, 0);
    chk("t2_ack_alarm", 32'(bus.alarm), 32'd0);
    chk("t2_ack_running", 32'(bus.running), 32'd0);
`endif

    // Pause at clk 15 holds the count; resume finishes the partial tick 5 clk later.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 3);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    for (int n = 1; n <= 14; n++) idle();
    cycle(0, 1, 0, 0, 0, 0);
    chk("t3_paused_rem", 32'(bus.remaining), 32'd2);
    chk("t3_paused_run", 32'(bus.running), 32'd0);
    for (int n = 0; n < 100; n++) idle();
    chk("t3_held_rem", 32'(bus.remaining), 32'd2);
    cycle(0, 1, 0, 0, 0, 0);
    chk("t3_resumed_run", 32'(bus.running), 32'd1);
    for (int n = 0; n < 4; n++) idle();
    chk("t3_before_tick", 32'(bus.remaining), 32'd2);
    idle();
    chk("t3_after_tick", 32'(bus.remaining), 32'd1);

    // Store into a slot while running changes the slot but not the count.
    cycle(0, 0, 0, 1, 1, 7);
    chk("t4_store_run_rem", 32'(bus.remaining), 32'd1);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 1, 0);
    chk("t4_store_readback", 32'(bus.remaining), 32'd7);

    // Reset in the middle of a run: everything including slots clears.
    cycle(0, 0, 0, 1, 2, 4);
    cycle(0, 0, 1, 0, 2, 0);
    cycle(0, 1, 0, 0, 0, 0);
    idle();
    idle();
    chk("t5_pre_rem", 32'(bus.remaining), 32'd4);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t5_rem", 32'(bus.remaining), 32'd0);
    chk("t5_run", 32'(bus.running), 32'd0);
    chk("t5_done", 32'(bus.done), 32'd0);
    for (int s = 0; s < MS; s++) begin
      cycle(0, 0, 1, 0, s, 0);
      chk($sformatf("t5_slot%0d", s), 32'(bus.remaining), 32'd0);
    end

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    cycle(0, 0, 0, 1, 0, 2);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    done_cnt = 0;
    alarm_seen = 0;
    for (int n = 1; n <= 60; n++) begin
      idle();
      if (bus.alarm === 1'b1) alarm_seen++;
      if (bus.done === 1'b1) done_cnt++;
      if (n == 10) chk("t6_rem_10", 32'(bus.remaining), 32'd1);
      if (n == 20) chk("t6_done_20", 32'(bus.done), 32'd1);
      if (n == 20) chk("t6_rem_20", 32'(bus.remaining), 32'd2);
      if (n == 40) chk("t6_done_40", 32'(bus.done), 32'd1);
    end
    chk("t6_done_count", 32'(done_cnt), 32'd3);
    chk("t6_alarm_never", 32'(alarm_seen), 32'd0);
`endif

    // Random traffic, compared cycle by cycle against the model.
    cycle(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      cycle(($urandom_range(0, 499) == 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 3)),
            int'($urandom_range(0, 12)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
